display_time_selector: RTL

Output stage between the time sources (power-on timer, accumulated work time, gesture countdown) and the board's two 7-segment groups. It debounces the two view-select keys and runs a three-way source selection FSM. It then time-multiplexes the selected BCD time onto six digits with a scan counter, so the top level no longer muxes segment buses combinationally. All outputs are registered.

---
 rtl/display_time_selector.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/display_time_selector.sv
// Display output stage: debounces the view keys, selects the time source and
// scans the selected BCD time onto two 3-digit 7-segment groups.
module display_time_selector #(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned SCAN_DIV        = 100_000,
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        power_state,
  input  logic        work_time_key,
  input  logic        gesture_time_key,
  input  logic [23:0] uptime_bcd,
  input  logic [23:0] worktime_bcd,
  input  logic [7:0]  gesture_bcd,
  output logic [7:0]  tub_segments_1,
  output logic [7:0]  tub_segments_2,
  output logic [5:0]  tub_select,
  output logic [1:0]  display_src
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  if (CLK_HZ < SCAN_DIV) begin : g_param_check
    $error("display_time_selector: SCAN_DIV exceeds CLK_HZ");
  end

  typedef enum logic [1:0] {
    S_UPTIME  = 2'b00,
    S_WORK    = 2'b01,
    S_GESTURE = 2'b10
  } src_state_t;

  src_state_t state_q, state_d;

  // Key conditioning; index 0 = work key, index 1 = gesture key.
  logic [1:0]      key_raw, key_s1, key_s2, key_deb, key_deb_d, key_rise;
  logic [DB_W-1:0] db_cnt [2];

  assign key_raw  = {gesture_time_key, work_time_key};
  assign key_rise = key_deb & ~key_deb_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_s1    <= '0;
      key_s2    <= '0;
      key_deb   <= '0;
      key_deb_d <= '0;
      for (int unsigned i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      key_s1    <= key_raw;
      key_s2    <= key_s1;
      key_deb_d <= key_deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (key_s2[i] == key_deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          key_deb[i] <= key_s2[i];
          db_cnt[i]  <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_UPTIME;
    else        state_q <= state_d;
  end

  // A press while the other key is held, or both together, falls back to uptime.
  always_comb begin
    state_d = state_q;
    if (!power_state) begin
      state_d = S_UPTIME;
    end else if (key_rise[0] && key_rise[1]) begin
      state_d = S_UPTIME;
    end else if (key_rise[0]) begin
      if (key_deb[1] || state_q == S_WORK) state_d = S_UPTIME;
      else                                  state_d = S_WORK;
    end else if (key_rise[1]) begin
      if (key_deb[0] || state_q == S_GESTURE) state_d = S_UPTIME;
      else                                     state_d = S_GESTURE;
    end
  end

  logic [SCAN_W-1:0] scan_cnt;
  logic [2:0]        digit_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_cnt  <= '0;
      digit_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_idx <= (digit_idx == 3'd5) ? 3'd0 : digit_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  function automatic logic [7:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    seg_decode = 8'h3F;
      4'd1:    seg_decode = 8'h06;
      4'd2:    seg_decode = 8'h5B;
      4'd3:    seg_decode = 8'h4F;
      4'd4:    seg_decode = 8'h66;
      4'd5:    seg_decode = 8'h6D;
      4'd6:    seg_decode = 8'h7D;
      4'd7:    seg_decode = 8'h07;
      4'd8:    seg_decode = 8'h7F;
      4'd9:    seg_decode = 8'h6F;
      default: seg_decode = 8'h40;
    endcase
  endfunction

  logic [23:0] src_bus;
  logic [3:0]  nib;
  logic        dp, lit;
  logic [7:0]  seg;
  logic [7:0]  seg1_d, seg2_d;
  logic [5:0]  sel_d;

  always_comb begin
    sel_d   = '0;
    seg1_d  = '0;
    seg2_d  = '0;
    nib     = '0;
    dp      = 1'b0;
    lit     = 1'b0;
    src_bus = (state_q == S_WORK) ? worktime_bcd : uptime_bcd;
    if (state_q == S_GESTURE) begin
      if (digit_idx == 3'd4) begin
        lit = 1'b1;
        nib = gesture_bcd[7:4];
      end else if (digit_idx == 3'd5) begin
        lit = 1'b1;
        nib = gesture_bcd[3:0];
      end
    end else begin
      lit = 1'b1;
      dp  = (digit_idx == 3'd1) || (digit_idx == 3'd3);
      case (digit_idx)
        3'd0:    nib = src_bus[23:20];
        3'd1:    nib = src_bus[19:16];
        3'd2:    nib = src_bus[15:12];
        3'd3:    nib = src_bus[11:8];
        3'd4:    nib = src_bus[7:4];
        3'd5:    nib = src_bus[3:0];
        default: lit = 1'b0;
      endcase
    end
    seg = seg_decode(nib) | {dp, 7'b0};
    if (power_state && lit) begin
      sel_d = 6'b000001 << digit_idx;
      if (digit_idx < 3'd3) seg1_d = seg;
      else                  seg2_d = seg;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tub_select     <= '0;
      tub_segments_1 <= '0;
      tub_segments_2 <= '0;
      display_src    <= '0;
    end else begin
      tub_select     <= sel_d;
      tub_segments_1 <= seg1_d;
      tub_segments_2 <= seg2_d;
      display_src    <= state_q;
    end
  end

endmodule
